// File: rtl/cpu6_trap_ctrl.sv
// cpu6 trap-entry / trap-return controller: detects exceptions, mret and the
// external interrupt in execute, writes mepc/mcause, flushes, and redirects fetch.
module cpu6_trap_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_illegal,
  input  logic            ex_ebreak,
  input  logic            ex_ecall,
  input  logic            ex_mret,
  input  logic            ext_irq,
  input  logic            irq_en,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] excp_mepc,
  output logic            excp_mepc_ena,
  output logic [XLEN-1:0] excp_mcause,
  output logic            excp_mcause_ena,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            trap_busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [XLEN-1:0] CAUSE_IRQ     = (XLEN'(1) << (XLEN-1)) | XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_EBREAK  = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
  localparam logic [XLEN-1:0] CLR_BIT0      = ~XLEN'(1);

  state_t          state, state_nxt;
  logic            is_mret_q;
  logic [XLEN-1:0] mepc_q, mcause_q, target_q;

  logic            irq, trap_det, event_det;
  logic [XLEN-1:0] cause_nxt, base, target_nxt;

  // Event detection and target computation from the instruction in execute
  always_comb begin
    irq       = ext_irq & irq_en;
    trap_det  = ex_valid & (irq | ex_illegal | ex_ebreak | ex_ecall);
    event_det = trap_det | (ex_valid & ex_mret);

    cause_nxt = '0;
    if (irq)             cause_nxt = CAUSE_IRQ;
    else if (ex_illegal) cause_nxt = CAUSE_ILLEGAL;
    else if (ex_ebreak)  cause_nxt = CAUSE_EBREAK;
    else if (ex_ecall)   cause_nxt = CAUSE_ECALL;

    base = {mtvec[XLEN-1:2], 2'b00};
    if (!trap_det)
      target_nxt = mepc & CLR_BIT0;
    else if (mtvec[1:0] == 2'b01 && irq)
      target_nxt = base + {cause_nxt[XLEN-3:0], 2'b00};
    else
      target_nxt = base;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (event_det) state_nxt = FLUSH;
      FLUSH:    state_nxt = REDIRECT;
      REDIRECT: if (redirect_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      is_mret_q <= 1'b0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      target_q  <= '0;
    end else begin
      state <= state_nxt;
      // mret only loads the target; mepc/mcause keep the last trap's values
      if (state == IDLE && event_det) begin
        target_q  <= target_nxt;
        is_mret_q <= ~trap_det;
        if (trap_det) begin
          mepc_q   <= ex_pc & CLR_BIT0;
          mcause_q <= cause_nxt;
        end
      end
    end
  end

  always_comb begin
    flush           = (state == FLUSH);
    excp_mepc_ena   = (state == FLUSH) & ~is_mret_q;
    excp_mcause_ena = (state == FLUSH) & ~is_mret_q;
    redirect_valid  = (state == REDIRECT);
    trap_busy       = (state != IDLE);
    excp_mepc       = mepc_q;
    excp_mcause     = mcause_q;
    redirect_pc     = target_q;
  end

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// Self-checking bench for cpu6_trap_ctrl: directed vector table, hand-written
// stall/reset sequences, and randomized traffic against a behavioural model.
module tb_cpu6_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_illegal, ex_ebreak, ex_ecall, ex_mret;
  logic [31:0] ex_pc, mtvec, mepc;
  logic        ext_irq, irq_en, redirect_ready;
  logic [31:0] excp_mepc, excp_mcause, redirect_pc;
  logic        excp_mepc_ena, excp_mcause_ena, flush, redirect_valid, trap_busy;

  int errors = 0;
  int checks = 0;

  cpu6_trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_illegal(ex_illegal), .ex_ebreak(ex_ebreak), .ex_ecall(ex_ecall), .ex_mret(ex_mret),
    .ext_irq(ext_irq), .irq_en(irq_en), .mtvec(mtvec), .mepc(mepc),
    .excp_mepc(excp_mepc), .excp_mepc_ena(excp_mepc_ena),
    .excp_mcause(excp_mcause), .excp_mcause_ena(excp_mcause_ena),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .trap_busy(trap_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid, ill, ebr, ecl, mret, irq, irq_en;
    logic [31:0] pc, mtvec, mepc;
    logic        exp_trap;
    logic [31:0] exp_cause, exp_mepc, exp_target;
  } vec_t;

  vec_t vecs[8];

  // behavioural model: phase 0 idle, 1 flush cycle, 2 waiting for redirect accept
  int          m_phase;
  logic        m_mret;
  logic [31:0] m_mepc, m_mcause, m_target;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ex_illegal = 0; ex_ebreak = 0; ex_ecall = 0; ex_mret = 0;
    ext_irq = 0; irq_en = 0; ex_pc = '0; mtvec = '0; mepc = '0;
  endtask

  task automatic model_step();
    logic        is_irq;
    logic [31:0] cause;
    if (reset) begin
      m_phase = 0; m_mret = 0; m_mepc = '0; m_mcause = '0; m_target = '0;
    end else if (m_phase == 0) begin
      is_irq = ext_irq && irq_en;
      if (ex_valid && (is_irq || ex_illegal || ex_ebreak || ex_ecall)) begin
        cause = is_irq ? 32'h8000_0000 + 11 : ex_illegal ? 2 : ex_ebreak ? 3 : 11;
        m_mcause = cause;
        m_mepc   = ex_pc - (ex_pc % 2);
        m_mret   = 0;
        if (is_irq && (mtvec % 4) == 1) m_target = mtvec - 1 + 4 * 11;
        else                            m_target = mtvec - (mtvec % 4);
        m_phase = 1;
      end else if (ex_valid && ex_mret) begin
        m_mret = 1; m_target = mepc - (mepc % 2); m_phase = 1;
      end
    end else if (m_phase == 1) m_phase = 2;
    else if (redirect_ready) m_phase = 0;
  endtask

  task automatic model_compare();
    check("rnd_flush",  {31'b0, flush},           {31'b0, m_phase == 1});
    check("rnd_mepc_ena", {31'b0, excp_mepc_ena}, {31'b0, m_phase == 1 && !m_mret});
    check("rnd_mcause_ena", {31'b0, excp_mcause_ena}, {31'b0, m_phase == 1 && !m_mret});
    check("rnd_rvalid", {31'b0, redirect_valid},  {31'b0, m_phase == 2});
    check("rnd_busy",   {31'b0, trap_busy},       {31'b0, m_phase != 0});
    check("rnd_mepc",   excp_mepc,   m_mepc);
    check("rnd_mcause", excp_mcause, m_mcause);
    if (m_phase == 2) check("rnd_rpc", redirect_pc, m_target);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_mepc"},   excp_mepc, 32'h0);
    check({tag, "_mcause"}, excp_mcause, 32'h0);
    check({tag, "_rpc"},    redirect_pc, 32'h0);
    check({tag, "_ctl"}, {27'b0, excp_mepc_ena, excp_mcause_ena, flush, redirect_valid, trap_busy}, 32'h0);
  endtask

  initial begin
    vecs[0] = '{"ecall",       1,0,0,1,0,0,0, 32'h0000_1002, 32'h0000_0100, 32'h0, 1, 32'd11,        32'h0000_1002, 32'h0000_0100};
    vecs[1] = '{"irq_vec",     1,1,0,0,0,1,1, 32'h0000_2000, 32'h0000_0201, 32'h0, 1, 32'h8000_000B, 32'h0000_2000, 32'h0000_022C};
    vecs[2] = '{"mret",        1,0,0,0,1,0,0, 32'h0000_3000, 32'h0000_0100, 32'h0000_4001, 0, 32'h0, 32'h0, 32'h0000_4000};
    vecs[3] = '{"ill_vec_exc", 1,1,1,0,0,0,1, 32'h0000_3003, 32'h0000_0301, 32'h0, 1, 32'd2,  32'h0000_3002, 32'h0000_0300};
    vecs[4] = '{"ebreak_m2",   1,0,1,1,0,0,0, 32'h0000_5004, 32'h0000_0402, 32'h0, 1, 32'd3,  32'h0000_5004, 32'h0000_0400};
    vecs[5] = '{"irq_m3",      1,0,0,0,0,1,1, 32'h0000_6008, 32'h0000_0503, 32'h0, 1, 32'h8000_000B, 32'h0000_6008, 32'h0000_0500};
    vecs[6] = '{"irq_wrap",    1,0,0,0,0,1,1, 32'hFFFF_FFFF, 32'hFFFF_FFE1, 32'h0, 1, 32'h8000_000B, 32'hFFFF_FFFE, 32'h0000_000C};
    vecs[7] = '{"ecall_mret",  1,0,0,1,1,0,0, 32'h0000_7010, 32'h0000_0800, 32'h0000_9000, 1, 32'd11, 32'h0000_7010, 32'h0000_0800};

    clear_inputs();
    reset = 1; redirect_ready = 1;
    tick(); tick();
    reset = 0;
    check_idle_zero("reset");

    foreach (vecs[i]) begin
      ex_valid = vecs[i].valid; ex_illegal = vecs[i].ill; ex_ebreak = vecs[i].ebr;
      ex_ecall = vecs[i].ecl; ex_mret = vecs[i].mret; ext_irq = vecs[i].irq;
      irq_en = vecs[i].irq_en; ex_pc = vecs[i].pc; mtvec = vecs[i].mtvec; mepc = vecs[i].mepc;
      redirect_ready = 1;
      tick();
      clear_inputs();
      check({vecs[i].name, "_t1_ctl"}, {28'b0, excp_mepc_ena, excp_mcause_ena, flush, trap_busy},
            {28'b0, vecs[i].exp_trap, vecs[i].exp_trap, 1'b1, 1'b1});
      if (vecs[i].exp_trap) begin
        check({vecs[i].name, "_mcause"}, excp_mcause, vecs[i].exp_cause);
        check({vecs[i].name, "_mepc"},   excp_mepc,   vecs[i].exp_mepc);
      end
      tick();
      check({vecs[i].name, "_t2_ctl"}, {27'b0, excp_mepc_ena, excp_mcause_ena, flush, redirect_valid, trap_busy},
            32'b00011);
      check({vecs[i].name, "_rpc"}, redirect_pc, vecs[i].exp_target);
      tick();
      check({vecs[i].name, "_t3_idle"}, {30'b0, redirect_valid, trap_busy}, 32'b0);
    end

    // irq masked, or flags without ex_valid: nothing happens
    ext_irq = 1; irq_en = 0; ex_valid = 1;
    tick();
    check("irq_masked", {29'b0, excp_mcause_ena, flush, trap_busy}, 32'b0);
    clear_inputs(); ex_ecall = 1; ext_irq = 1; irq_en = 1;
    tick();
    check("no_valid", {29'b0, excp_mepc_ena, flush, trap_busy}, 32'b0);
    clear_inputs();

    // redirect stall with ecall toggling: no recapture, target stable
    ex_valid = 1; ex_ecall = 1; ex_pc = 32'h0000_0600; mtvec = 32'h0000_0700;
    redirect_ready = 0;
    tick();
    ex_pc = 32'h0000_0A00; mtvec = 32'h0000_0B00; mepc = 32'h0000_0C00;
    tick();
    for (int c = 0; c < 3; c++) begin
      ex_ecall = ~ex_ecall; ex_illegal = ex_ecall;
      check("stall_rv",   {30'b0, redirect_valid, trap_busy}, 32'b11);
      check("stall_rpc",  redirect_pc, 32'h0000_0700);
      check("stall_strb", {30'b0, excp_mepc_ena, flush}, 32'b0);
      tick();
    end
    clear_inputs();
    redirect_ready = 1;
    check("accept_rv", {30'b0, redirect_valid, trap_busy}, 32'b11);
    tick();
    check("after_accept", {30'b0, redirect_valid, trap_busy}, 32'b0);
    check("no_recapture_mcause", excp_mcause, 32'd11);
    check("no_recapture_mepc",   excp_mepc,   32'h0000_0600);

    // reset during REDIRECT, then a normal ecall
    ex_valid = 1; ex_ebreak = 1; ex_pc = 32'h0000_0D00; mtvec = 32'h0000_0E00;
    redirect_ready = 0;
    tick();
    clear_inputs();
    tick();
    check("pre_reset_rv", {31'b0, redirect_valid}, 32'b1);
    reset = 1;
    tick();
    reset = 0;
    check_idle_zero("redir_reset");
    redirect_ready = 1;
    ex_valid = 1; ex_ecall = 1; ex_pc = 32'h0000_0800; mtvec = 32'h0000_0900;
    tick();
    clear_inputs();
    check("post_reset_strb", {29'b0, excp_mepc_ena, excp_mcause_ena, flush}, 32'b111);
    check("post_reset_mcause", excp_mcause, 32'd11);
    check("post_reset_mepc",   excp_mepc,   32'h0000_0800);
    tick();
    check("post_reset_rpc", redirect_pc, 32'h0000_0900);
    tick();
    check("post_reset_idle", {31'b0, trap_busy}, 32'b0);

    // randomized traffic against the model
    reset = 1;
    model_step();
    tick();
    reset = 0;
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 63) == 0);
      ex_valid       = ($urandom_range(0, 9) < 7);
      ex_illegal     = ($urandom_range(0, 7) == 0);
      ex_ebreak      = ($urandom_range(0, 7) == 0);
      ex_ecall       = ($urandom_range(0, 7) == 0);
      ex_mret        = ($urandom_range(0, 7) == 0);
      ext_irq        = ($urandom_range(0, 4) == 0);
      irq_en         = $urandom_range(0, 1) == 1;
      redirect_ready = $urandom_range(0, 1) == 1;
      ex_pc          = $urandom;
      mtvec          = $urandom;
      mepc           = $urandom;
      model_step();
      tick();
      model_compare();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
